// File: rtl/alarm_display_mux.sv
// Multi-channel alarm display: registers NUM_CH 3-bit alarm codes, latches
// error codes until acknowledged, and scans one common-anode 7-segment digit
// per channel with optional blinking of latched errors.
module alarm_display_mux #(
  parameter int NUM_CH       = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic [3*NUM_CH-1:0]   alarm_codes,
  input  logic                  blink_en,
  input  logic                  ack,
  output logic [7:0]            seg,
  output logic [NUM_CH-1:0]     an,
  output logic                  alarm_any
);

  localparam int IDX_W  = (NUM_CH > 1)       ? $clog2(NUM_CH)       : 1;
  localparam int SCAN_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Active-low segment patterns {a,b,c,d,e,f,g,dp}, dp always off
  localparam logic [7:0] GLYPH_O     = 8'hC5;
  localparam logic [7:0] GLYPH_L     = 8'hE3;
  localparam logic [7:0] GLYPH_H     = 8'h91;
  localparam logic [7:0] GLYPH_E     = 8'h61;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  logic [NUM_CH-1:0][2:0] code_q;
  logic [NUM_CH-1:0]      err;
  logic [SCAN_W-1:0]      scan_cnt;
  logic [IDX_W-1:0]       idx;
  logic [BLK_W-1:0]       blink_cnt;
  logic                   blink_phase;

  logic                   scan_tc;
  logic                   idx_last;
  logic                   frame_end;
  logic                   blink_tc;
  logic [2:0]             cur_code;
  logic                   cur_err;
  logic [7:0]             seg_d;
  logic [NUM_CH-1:0]      an_d;
  logic                   any_d;

  // Input stage: all decoding works from the registered codes
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) code_q <= '0;
    else          code_q <= alarm_codes;
  end

  // Sticky error latches; a live error code overrides a simultaneous ack
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      err <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (code_q[k][2])  err[k] <= 1'b1;
        else if (ack)      err[k] <= 1'b0;
      end
    end
  end

  // Terminal-count decodes for scan, frame and blink timing
  always_comb begin
    scan_tc   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    idx_last  = (idx == IDX_W'(NUM_CH - 1));
    frame_end = scan_tc && idx_last;
    blink_tc  = (blink_cnt == BLK_W'(BLINK_FRAMES - 1));
  end

  // Digit scan and blink timebase
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      scan_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_tc) scan_cnt <= '0;
      else         scan_cnt <= scan_cnt + SCAN_W'(1);

      if (scan_tc) begin
        if (idx_last) idx <= '0;
        else          idx <= idx + IDX_W'(1);
      end

      if (frame_end) begin
        if (blink_tc) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Select the scanned channel, build its glyph and the global alarm flag
  always_comb begin
    cur_code = '0;
    cur_err  = 1'b0;
    an_d     = '1;
    any_d    = 1'b0;
    seg_d    = GLYPH_BLANK;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_code = code_q[k];
        cur_err  = err[k];
        an_d[k]  = 1'b0;
      end
      any_d = any_d | err[k] | (code_q[k] == 3'b001) | (code_q[k] == 3'b010);
    end
    if (blink_en && blink_phase && cur_err) begin
      seg_d = GLYPH_BLANK;
    end else if (cur_err) begin
      seg_d = GLYPH_E;
    end else begin
      casez (cur_code)
        3'b1??:  seg_d = GLYPH_E;
        3'b000:  seg_d = GLYPH_O;
        3'b001:  seg_d = GLYPH_L;
        3'b010:  seg_d = GLYPH_H;
        default: seg_d = GLYPH_BLANK;
      endcase
    end
  end

  // Output registers: no combinational path from pins to display
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      seg       <= GLYPH_BLANK;
      an        <= '1;
      alarm_any <= 1'b0;
    end else begin
      seg       <= seg_d;
      an        <= an_d;
      alarm_any <= any_d;
    end
  end

endmodule
